vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Arbiter for the VGA frame buffer's single memory port, shared between the scan-out pixel fetcher and the CPU bus slave. Scan-out normally has priority. A stall counter guarantees the CPU a slot after a bounded wait. The block sits between the VGA peripheral's bus interface and the frame-buffer RAM, and owns the bus handshake (`response_o`, `read_data_o`) for frame-buffer accesses.

## Interface
- `VGA_WIDTH`, 640, active pixels per line.
- `VGA_HEIGHT`, 480, active lines.
- `PIXEL_W`, 24, frame-buffer word width (1, 8 or 24).
- `MAX_STALL`, 4, consecutive CPU-denied cycles before the CPU is forced a grant; range 1..15.
- `ADDR_W`, derived, clog2(VGA_WIDTH*VGA_HEIGHT).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- `read_request_i`  in  1  CPU read request; held until `response_o`.
- `write_request_i`  in  1  CPU write request; held until `response_o`.
- `address_i`  in  32  byte address; pixel index = `address_i[ADDR_W+1:2]`.
- `write_data_i`  in  32  write data; low `PIXEL_W` bits used.
- `read_data_o`  out  32  read data, zero-extended.
- `response_o`  out  1  one-cycle completion pulse.
- `fetch_req_i`  in  1  scan-out fetch request; held until granted.
- `fetch_addr_i`  in  ADDR_W  scan-out pixel index.
- `fetch_gnt_o`  out  1  combinational grant to scan-out.
- `fetch_valid_o`  out  1  fetched pixel valid, one cycle after grant.
- `fetch_data_o`  out  PIXEL_W  fetched pixel.
- `mem_en_o`, `mem_we_o`  out  1  RAM enable / write enable.
- `mem_addr_o`  out  ADDR_W  RAM address.
- `mem_wdata_o`  out  PIXEL_W  RAM write data.
- `mem_rdata_i`  in  PIXEL_W  RAM read data, 1-cycle latency.

## Operation
- **FSM states:** IDLE, READ_WAIT, RESPOND.
- **CPU pending:** CPU requests are sampled only in IDLE. In READ_WAIT and RESPOND they are ignored.
- **Simultaneous requests:** if `read_request_i` and `write_request_i` are both high, the access is a write.
- **Arbitration in IDLE:**
  - If `fetch_req_i` is high and the stall counter is below `MAX_STALL`, scan-out wins. `fetch_gnt_o` = 1. If a CPU request is pending, the stall counter increments.
  - Otherwise a pending CPU request wins and the stall counter clears.
- **Outside IDLE:** scan-out always wins.
- **Stall counter:** 4 bits, saturating. It clears on any CPU grant and whenever the CPU is not pending.
- **CPU write:** drives `mem_en_o` = `mem_we_o` = 1, then goes to RESPOND.
- **CPU read:** drives `mem_en_o` = 1, then goes to READ_WAIT. READ_WAIT registers `mem_rdata_i` into `read_data_o`, then goes to RESPOND.
- **RESPOND:** `response_o` = 1 for exactly one cycle, then returns to IDLE.
- **Out-of-range access:** a pixel index ≥ VGA_WIDTH*VGA_HEIGHT gets no RAM access. The write is dropped; a read returns 0. Timing is the same as an in-range access.
- **Scan-out fetch:** `fetch_valid_o` is `fetch_gnt_o` delayed one cycle. `fetch_data_o` = `mem_rdata_i`, passed through.
- **Forced CPU grant:** `fetch_gnt_o` = 0 in that cycle. The scan-out side keeps its request and retries; its line buffer absorbs the gap.

## Timing
- **Reset values:** every output is 0, state = IDLE, stall counter = 0. Assertion mid-transaction aborts it and produces no `response_o`.
- **CPU write** granted in cycle t: `response_o` in t+1.
- **CPU read** granted in cycle t: data captured at the end of t+1; `response_o` and `read_data_o` valid in t+2. `read_data_o` holds until the next read.
- **Worst-case CPU grant latency:** `MAX_STALL`+1 cycles under continuous scan-out load.
- **Scan-out:** grant in t, data valid in t+1. Back-to-back grants are allowed every cycle.
- **RAM port:** at most one RAM operation per cycle. A CPU read and a scan-out grant never coincide in the same cycle.
- **Master rule:** the bus master must drop its request in the `response_o` cycle. RESPOND guarantees the request is not re-sampled in that cycle.

## Structure
- **`vga_pkg`:** holds the `fb_state_t` enum (IDLE, READ_WAIT, RESPOND) and localparams for the default resolution, `PIXEL_W` per colour mode (BLACK_AND_WHITE / GRAY_SCALE / RGB), and the stall-counter width.
- **Sub-modules:** none. FSM, grant logic and stall counter stay in one module. The RAM is instantiated by the parent VGA peripheral.

## Test plan
- **Write then read:** write 0x00ABCDEF to 0x00000010 with scan-out idle → `mem_we_o` at t with `mem_addr_o` = 4, `response_o` at t+1. A read of the same address → `response_o` at t+2 with `read_data_o` = 0x00ABCDEF.
- **Stall limit:** `fetch_req_i` held at 1 continuously, CPU read pending, `MAX_STALL` = 4 → 4 scan-out grants, then the CPU is granted on the 5th cycle with `fetch_gnt_o` = 0 in that cycle; `fetch_valid_o` follows each grant by 1 cycle.
- **Out of range:** read of 0x0012C000 (index 307200) → no `mem_en_o`, `response_o` at t+2, `read_data_o` = 0. Write there → RAM untouched.
- **Simultaneous request:** read and write both high → treated as a write; only one `response_o` pulse.
- **Reset mid-read:** `rst_n` low in READ_WAIT → all outputs 0 immediately. After release the FSM is in IDLE and no `response_o` appears.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer path.
// Holds the arbiter FSM state type, default resolution and pixel widths.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      RESPOND
   } fb_state_t;

   typedef enum logic [1:0] {
      BLACK_AND_WHITE,
      GRAY_SCALE,
      RGB
   } color_mode_t;

   localparam int DEF_WIDTH    = 640;
   localparam int DEF_HEIGHT   = 480;

   localparam int PIXEL_W_BW   = 1;
   localparam int PIXEL_W_GRAY = 8;
   localparam int PIXEL_W_RGB  = 24;

   localparam int STALL_W      = 4;

   function automatic int pixel_w(input color_mode_t m);
      unique case (m)
         BLACK_AND_WHITE: return PIXEL_W_BW;
         GRAY_SCALE:      return PIXEL_W_GRAY;
         default:         return PIXEL_W_RGB;
      endcase
   endfunction

endpackage

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM port arbiter: scan-out fetcher vs CPU bus slave.
// Ports: clk/rst_n; CPU bus (read/write request, address, data,
// response); scan-out fetch (req, addr, gnt, valid, data); RAM port.
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int VGA_WIDTH  = DEF_WIDTH,
   parameter int VGA_HEIGHT = DEF_HEIGHT,
   parameter int PIXEL_W    = PIXEL_W_RGB,
   parameter int MAX_STALL  = 4,
   localparam int ADDR_W    = $clog2(VGA_WIDTH*VGA_HEIGHT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               read_request_i,
   input  logic               write_request_i,
   input  logic [31:0]        address_i,
   input  logic [31:0]        write_data_i,
   output logic [31:0]        read_data_o,
   output logic               response_o,
   input  logic               fetch_req_i,
   input  logic [ADDR_W-1:0]  fetch_addr_i,
   output logic               fetch_gnt_o,
   output logic               fetch_valid_o,
   output logic [PIXEL_W-1:0] fetch_data_o,
   output logic               mem_en_o,
   output logic               mem_we_o,
   output logic [ADDR_W-1:0]  mem_addr_o,
   output logic [PIXEL_W-1:0] mem_wdata_o,
   input  logic [PIXEL_W-1:0] mem_rdata_i
);

   localparam int AW1 = ADDR_W + 1;
   localparam logic [ADDR_W:0] NPIX =
      AW1'(VGA_WIDTH * VGA_HEIGHT);
   localparam logic [STALL_W-1:0] MAX_S =
      STALL_W'(MAX_STALL);

   fb_state_t           state;
   logic [STALL_W-1:0]  stall;
   logic                rd_oor;

   logic [ADDR_W-1:0]   cpu_idx;
   logic                in_range;
   logic                idle;
   logic                cpu_pend;
   logic                fetch_win;
   logic                cpu_gnt;
   logic                unused_bits;

   assign cpu_idx  = address_i[ADDR_W+1:2];
   assign in_range = {1'b0, cpu_idx} < NPIX;
   assign idle     = (state == IDLE);
   assign cpu_pend = idle &
                     (read_request_i | write_request_i);

   // Scan-out wins everywhere except IDLE with the stall
   // counter at its limit, which forces the CPU slot.
   assign fetch_win = fetch_req_i &
                      (!idle || (stall < MAX_S));

   // Grants are gated by rst_n so every output reads 0 the
   // moment reset is asserted, even with requests held high.
   assign cpu_gnt     = rst_n & cpu_pend & !fetch_win;
   assign fetch_gnt_o = rst_n & fetch_win;

   // Out-of-range CPU accesses keep their timing but never
   // touch the RAM.
   assign mem_en_o = fetch_gnt_o | (cpu_gnt & in_range);
   assign mem_we_o = cpu_gnt & write_request_i & in_range;

   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (cpu_gnt)
         mem_addr_o = cpu_idx;
      else if (fetch_gnt_o)
         mem_addr_o = fetch_addr_i;
      if (mem_we_o)
         mem_wdata_o = write_data_i[PIXEL_W-1:0];
   end

   assign fetch_data_o = rst_n ? mem_rdata_i : '0;

   assign unused_bits = ^{address_i[31:ADDR_W+2],
                          address_i[1:0],
                          write_data_i[31:PIXEL_W]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         stall         <= '0;
         rd_oor        <= 1'b0;
         response_o    <= 1'b0;
         read_data_o   <= '0;
         fetch_valid_o <= 1'b0;
      end else begin
         fetch_valid_o <= fetch_gnt_o;
         response_o    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cpu_gnt) begin
                  stall  <= '0;
                  rd_oor <= !in_range;
                  if (write_request_i) begin
                     state      <= RESPOND;
                     response_o <= 1'b1;
                  end else begin
                     state <= READ_WAIT;
                  end
               end else if (cpu_pend) begin
                  // CPU lost to scan-out this cycle.
                  if (stall != '1)
                     stall <= stall + 1'b1;
               end else begin
                  stall <= '0;
               end
            end
            READ_WAIT: begin
               read_data_o <= rd_oor ? '0 : 32'(mem_rdata_i);
               state       <= RESPOND;
               response_o  <= 1'b1;
            end
            RESPOND: begin
               // Request is not re-sampled here; master drops it.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
